// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI FT245 synchronous-FIFO frame receiver.
// Holds the FSM encoding, the SOF bit position and a width helper.
package ftdi_pkg;

    // Encoding chosen so oe_n = state[0] and rd_n = state[1] come straight from the register
    typedef enum logic [2:0] {
        IDLE  = 3'b011,
        START = 3'b010,
        READ  = 3'b100
    } state_t;

    localparam int SOF_BIT = 7;

    // Width of a byte index able to count 0..bpp-1 (at least one bit)
    function automatic int idx_w(input int bpp);
        return (bpp > 1) ? $clog2(bpp) : 1;
    endfunction

endpackage

// File: rtl/ftdi_rx_frame_packer.sv
// Packs BPP payload fields into one pixel word, first byte in the MSBs.
// A restart forces the incoming byte to be byte 0 of a new pixel.
module pixel_packer #(
    parameter int BPP    = 3,
    parameter int CHAN_W = 7,
    parameter int IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  restart,
    input  logic [CHAN_W-1:0]     din,
    output logic [IDX_W-1:0]      byte_idx,
    output logic [BPP*CHAN_W-1:0] word,
    output logic                  done
);

    localparam int WORD_W = BPP * CHAN_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPP - 1);

    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  cur_idx;

    // Older bytes fall off the top, so a restart needs no explicit flush
    always_comb begin
        cur_idx = restart ? '0 : byte_idx;
        word    = (shreg << CHAN_W) | WORD_W'(din);
        done    = push && (cur_idx == LAST_IDX);
    end

    // Shift register and byte position within the current pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (push) begin
            shreg    <= word;
            byte_idx <= done ? '0 : cur_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ftdi_rx_frame.sv
// FT245 synchronous-FIFO pixel receiver: reads bytes, packs pixels,
// writes one framebuffer word per pixel and stops on an exact frame.
module ftdi_rx_frame
    import ftdi_pkg::*;
#(
    parameter int BPP       = 3,
    parameter int CHAN_W    = 7,
    parameter int ADDR_W    = 14,
    parameter int FRAME_PIX = 16384,
    parameter int CNT_W     = 8
) (
    input  logic                  clk_60,
    input  logic                  rst,
    input  logic [7:0]            data_in,
    input  logic                  rxf_n,
    input  logic                  txe_n,
    output logic                  oe_n,
    output logic                  rd_n,
    output logic                  wr_n,
    output logic [BPP*CHAN_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0]     ram_waddr,
    output logic                  ram_we,
    output logic                  full,
    input  logic                  swapped,
    output logic                  frame_done,
    output logic                  err_pulse,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int IDX_W = idx_w(BPP);
    localparam int WORD_W = BPP * CHAN_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BPP - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIX - 1);

    state_t state;
    state_t state_nxt;

    logic              synced;
    logic [ADDR_W-1:0] pix_cnt;
    logic [ADDR_W-1:0] eff_pix;
    logic [IDX_W-1:0]  byte_idx;
    logic [WORD_W-1:0] word;
    logic              word_done;
    logic              sof;
    logic              accept;
    logic              take;
    logic              restart;
    logic              abandon;
    logic              misaligned;
    logic              wr_pix;
    logic              last_write;
    logic              last_byte;
    logic              unused_ok;

    assign unused_ok = ^{txe_n, data_in};

    // Byte qualification, sync and frame-position decisions
    always_comb begin
        sof     = data_in[SOF_BIT];
        accept  = (state == READ) && !rxf_n;
        take    = accept && (synced || sof);
        restart = take && sof;
        eff_pix = restart ? '0 : pix_cnt;
        last_write = word_done && (eff_pix == LAST_PIX);
        // Completing the frame takes priority over a swap seen on the same edge
        abandon = swapped && !full && !last_write;
        wr_pix  = word_done && !abandon;
        misaligned = restart && !abandon && synced &&
                     ((byte_idx != '0) || (pix_cnt != '0));
        last_byte = accept && (byte_idx == LAST_IDX) &&
                    (pix_cnt == LAST_PIX) && synced;
    end

    pixel_packer #(
        .BPP    (BPP),
        .CHAN_W (CHAN_W),
        .IDX_W  (IDX_W)
    ) u_packer (
        .clk      (clk_60),
        .rst      (rst),
        .clear    (abandon),
        .push     (take),
        .restart  (restart),
        .din      (data_in[CHAN_W-1:0]),
        .byte_idx (byte_idx),
        .word     (word),
        .done     (word_done)
    );

    // FSM state register
    always_ff @(posedge clk_60) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state: no new read burst starts while a frame waits for swap
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!rxf_n && !full) state_nxt = START;
            START: state_nxt = !rxf_n ? READ : IDLE;
            READ:  if (rxf_n || last_byte) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs decoded directly from the state bits
    always_comb begin
        oe_n = state[0];
        rd_n = state[1];
        wr_n = 1'b1;
    end

    // Pixel write, frame position, status and statistics
    always_ff @(posedge clk_60) begin
        if (rst) begin
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            full       <= 1'b0;
            frame_done <= 1'b0;
            err_pulse  <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            pix_cnt    <= '0;
            synced     <= 1'b0;
        end else begin
            ram_we     <= wr_pix;
            frame_done <= last_write;
            err_pulse  <= misaligned;
            if (wr_pix) begin
                ram_waddr <= eff_pix;
                ram_wdata <= word;
            end
            if (restart && !abandon)
                synced <= 1'b1;
            if (abandon)
                pix_cnt <= '0;
            else if (wr_pix)
                pix_cnt <= last_write ? '0 : eff_pix + 1'b1;
            else if (restart)
                pix_cnt <= '0;
            if (last_write)
                full <= 1'b1;
            else if (swapped)
                full <= 1'b0;
            if (last_write)
                frame_cnt <= frame_cnt + 1'b1;
            if (misaligned && (err_cnt != '1))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ftdi_rx_frame.sv
// Directed bench for ftdi_rx_frame with a byte FIFO model and a
// write scoreboard (BPP=3, CHAN_W=7, FRAME_PIX=4).
module tb_ftdi_rx_frame;

    localparam int BPP = 3;
    localparam int CHAN_W = 7;
    localparam int ADDR_W = 14;
    localparam int FRAME_PIX = 4;
    localparam int CNT_W = 8;
    localparam int WW = BPP * CHAN_W;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WW-1:0]     data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        data_in = 8'h00;
    logic              rxf_n = 1'b1;
    logic              txe_n = 1'b1;
    logic              swapped = 1'b0;
    logic              oe_n;
    logic              rd_n;
    logic              wr_n;
    logic [WW-1:0]     ram_wdata;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_we;
    logic              full;
    logic              frame_done;
    logic              err_pulse;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;

    logic [7:0] q[$];
    exp_t       sb[$];
    bit         hold = 1'b1;
    bit         take_pend = 1'b0;
    int         consumed = 0;
    int         nwrites = 0;
    int         fd_seen = 0;
    int         err_seen = 0;
    int         checks = 0;
    int         errors = 0;
    int         base;

    ftdi_rx_frame #(
        .BPP       (BPP),
        .CHAN_W    (CHAN_W),
        .ADDR_W    (ADDR_W),
        .FRAME_PIX (FRAME_PIX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_60     (clk),
        .rst        (rst),
        .data_in    (data_in),
        .rxf_n      (rxf_n),
        .txe_n      (txe_n),
        .oe_n       (oe_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .ram_wdata  (ram_wdata),
        .ram_waddr  (ram_waddr),
        .ram_we     (ram_we),
        .full       (full),
        .swapped    (swapped),
        .frame_done (frame_done),
        .err_pulse  (err_pulse),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: a byte is consumed on an edge where rd_n and rxf_n are both low
    always @(negedge clk) begin
        take_pend = !rd_n && !rxf_n;
        if (take_pend) consumed++;
    end

    always @(posedge clk) begin
        #1;
        if (take_pend && q.size() > 0) void'(q.pop_front());
        rxf_n = hold || (q.size() == 0);
        data_in = (q.size() > 0) ? q[0] : 8'h00;
    end

    // Write scoreboard and pulse counters
    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_seen++;
        if (err_pulse === 1'b1) err_seen++;
        if (ram_we === 1'b1) begin
            exp_t e;
            nwrites++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_extra: write %0h=%0h, expected no write",
                       ram_waddr, ram_wdata);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                assert ({ram_waddr, ram_wdata} === {e.addr, e.data}) else begin
                    errors++;
                    $error("FAIL sb_write: got %0h=%0h expected %0h=%0h",
                           ram_waddr, ram_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WW-1:0] pack(input logic [7:0] a, b, c);
        return {a[6:0], b[6:0], c[6:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_pix(input logic [7:0] a, b, c,
                            input int addr, input bit want);
        exp_t e;
        q.push_back(a);
        q.push_back(b);
        q.push_back(c);
        if (want) begin
            e.addr = ADDR_W'(addr);
            e.data = pack(a, b, c);
            sb.push_back(e);
        end
    endtask

    task automatic push_frame();
        push_pix(8'h81, 8'h02, 8'h03, 0, 1'b1);
        for (int i = 1; i < FRAME_PIX; i++)
            push_pix(8'h7F, 8'h7F, 8'h7F, i, 1'b1);
    endtask

    task automatic wait_full(input string tag);
        for (int i = 0; i < 200 && full !== 1'b1; i++) tick();
        chk(tag, full, 1);
    endtask

    task automatic wait_drain(input string tag);
        tick();
        for (int i = 0; i < 200 && !(q.size() == 0 && rxf_n === 1'b1); i++)
            tick();
        chk(tag, rxf_n, 1);
    endtask

    task automatic pulse_swap();
        swapped = 1'b1;
        tick();
        swapped = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_oe_n", oe_n, 1);
        chk("rst_rd_n", rd_n, 1);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_full", full, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_errp", err_pulse, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_ecnt", err_cnt, 0);

        // Sync hunt, handshake and exact frame fill
        q.push_back(8'h05);
        q.push_back(8'h06);
        push_frame();
        hold = 1'b0;
        for (int i = 0; i < 20 && oe_n !== 1'b0; i++) tick();
        chk("hs_oe_low", oe_n, 0);
        chk("hs_rd_still_high", rd_n, 1);
        tick();
        chk("hs_rd_low", rd_n, 0);
        wait_full("f1_full");
        tick();
        chk("f1_writes", nwrites, 4);
        chk("f1_fd_once", fd_seen, 1);
        chk("f1_fcnt", frame_cnt, 1);
        chk("f1_ecnt", err_cnt, 0);
        chk("f1_consumed", consumed, 14);
        chk("f1_sb_empty", sb.size(), 0);

        // Full blocks further reads
        q.push_back(8'h7F);
        repeat (10) tick();
        chk("full_no_read", consumed, 14);
        chk("full_rd_n", rd_n, 1);
        chk("full_held", full, 1);
        q.delete();
        repeat (2) tick();
        pulse_swap();
        chk("swap_clear", full, 0);
        chk("swap_fcnt", frame_cnt, 1);

        // Short frame, then rxf_n high returns strobes to idle
        push_pix(8'h81, 8'h02, 8'h03, 0, 1'b1);
        push_pix(8'h04, 8'h05, 8'h06, 1, 1'b1);
        wait_drain("short_drain");
        tick();
        chk("rxf_hi_oe_n", oe_n, 1);
        chk("rxf_hi_rd_n", rd_n, 1);
        chk("short_writes", nwrites, 6);
        chk("short_no_err", err_seen, 0);
        push_frame();
        wait_full("f2_full");
        tick();
        chk("short_errp", err_seen, 1);
        chk("short_ecnt", err_cnt, 1);
        chk("f2_fcnt", frame_cnt, 2);
        chk("f2_sb_empty", sb.size(), 0);

        // Swap on the same edge as the final byte: full still sets
        pulse_swap();
        chk("swap2_clear", full, 0);
        push_frame();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (q.size() == 1 && take_pend) break;
        end
        swapped = 1'b1;
        tick();
        swapped = 1'b0;
        chk("coll_full_wins", full, 1);
        tick();
        chk("coll_full_stays", full, 1);
        chk("coll_fcnt", frame_cnt, 3);
        chk("coll_sb_empty", sb.size(), 0);

        // Reset in the middle of pixel 2
        pulse_swap();
        base = nwrites;
        push_pix(8'h81, 8'h02, 8'h03, 0, 1'b1);
        push_pix(8'h04, 8'h05, 8'h06, 1, 1'b1);
        q.push_back(8'h07);
        q.push_back(8'h08);
        for (int i = 0; i < 200 && nwrites != base + 2; i++) tick();
        chk("mid_writes", nwrites, base + 2);
        chk("mid_reading", rd_n, 0);
        rst = 1'b1;
        hold = 1'b1;
        tick();
        chk("mrst_oe_n", oe_n, 1);
        chk("mrst_rd_n", rd_n, 1);
        chk("mrst_we", ram_we, 0);
        chk("mrst_full", full, 0);
        chk("mrst_fcnt", frame_cnt, 0);
        chk("mrst_ecnt", err_cnt, 0);
        rst = 1'b0;
        q.delete();
        tick();

        // Not synced after reset: bytes without SOF produce no writes
        base = nwrites;
        for (int i = 1; i <= 6; i++) q.push_back(8'(i));
        hold = 1'b0;
        wait_drain("unsync_drain");
        repeat (3) tick();
        chk("unsync_no_write", nwrites, base);
        chk("unsync_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
